// File: rtl/regfile_sb_if.sv
// regfile_sb_if
//   Bundles the register-file port signals between decode/writeback (master)
//   and the register file (slave).
//   Write port   : wr_en, wr_addr, wr_data
//   Read ports   : rd_addr_1/2 -> rd_data_1/2, busy_1/2 (combinational)
//   Scoreboard   : rsv_en, rsv_addr -> sb_err (sticky)
//   Debug/status : dbg_addr -> dbg_data (registered), wr_count
//   XLEN and AW must match the parameters of the regfile_sb instance.
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic [AW-1:0]   rd_addr_1;
  logic [AW-1:0]   rd_addr_2;
  logic [XLEN-1:0] rd_data_1;
  logic [XLEN-1:0] rd_data_2;
  logic            busy_1;
  logic            busy_2;
  logic            rsv_en;
  logic [AW-1:0]   rsv_addr;
  logic            sb_err;
  logic [AW-1:0]   dbg_addr;
  logic [XLEN-1:0] dbg_data;
  logic [31:0]     wr_count;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_1, rd_addr_2, rsv_en, rsv_addr, dbg_addr,
    input  rd_data_1, rd_data_2, busy_1, busy_2, sb_err, dbg_data, wr_count
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_1, rd_addr_2, rsv_en, rsv_addr, dbg_addr,
    output rd_data_1, rd_data_2, busy_1, busy_2, sb_err, dbg_data, wr_count
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb
//   Integer register file with an integrated write-pending scoreboard.
//   Two combinational read ports with write-through bypass, one write port,
//   optional hardwired-zero register 0, registered debug read port.
//   Ports:
//     clock : rising-edge clock
//     reset : asynchronous, active-low; clears registers, busy bits, sb_err,
//             dbg_data and wr_count
//     bus   : regfile_sb_if slave modport (see interface header)
//   An address is valid when it is < NREGS and not register 0 with ZERO_REG=1.
//   Invalid addresses read as zero, are never busy, and ignore writes and
//   reservations.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic        clock,
  input  logic        reset,
  regfile_sb_if.slave bus
);

  localparam logic [AW:0] NREGS_L = (AW+1)'(NREGS);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic             sb_err_q;
  logic [31:0]      wr_count_q;
  logic [XLEN-1:0]  dbg_q;

  logic wr_ok;
  logic rsv_ok;
  logic hit_1;
  logic hit_2;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < NREGS_L) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign wr_ok  = bus.wr_en && addr_ok(bus.wr_addr);
  assign rsv_ok = bus.rsv_en && addr_ok(bus.rsv_addr);

  // Raw address match is enough for bypass: the read side is already gated by
  // addr_ok on the same address, so an invalid write never leaks through.
  assign hit_1 = bus.wr_en && (bus.wr_addr == bus.rd_addr_1);
  assign hit_2 = bus.wr_en && (bus.wr_addr == bus.rd_addr_2);

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    bus.rd_data_1 = '0;
    bus.busy_1    = 1'b0;
    if (addr_ok(bus.rd_addr_1)) begin
      bus.rd_data_1 = hit_1 ? bus.wr_data : regs[bus.rd_addr_1];
      bus.busy_1    = busy[bus.rd_addr_1] && !hit_1;
    end
  end

  always_comb begin
    bus.rd_data_2 = '0;
    bus.busy_2    = 1'b0;
    if (addr_ok(bus.rd_addr_2)) begin
      bus.rd_data_2 = hit_2 ? bus.wr_data : regs[bus.rd_addr_2];
      bus.busy_2    = busy[bus.rd_addr_2] && !hit_2;
    end
  end

  // A write retires the pending producer; a reservation on the same edge
  // belongs to a newer producer, so it is applied last and wins.
  always_comb begin
    busy_nxt = busy;
    for (int i = 0; i < NREGS; i++) begin
      if (wr_ok && (bus.wr_addr == AW'(i)))   busy_nxt[i] = 1'b0;
      if (rsv_ok && (bus.rsv_addr == AW'(i))) busy_nxt[i] = 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values; dbg_q therefore sees storage before this edge's
  // write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: the storage array is reset explicitly because architectural
      // state must read as zero immediately after reset; this rules out a
      // RAM macro and keeps it as flops.
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy       <= '0;
      sb_err_q   <= 1'b0;
      wr_count_q <= '0;
      dbg_q      <= '0;
    end else begin
      if (wr_ok) begin
        regs[bus.wr_addr] <= bus.wr_data;
        wr_count_q        <= wr_count_q + 32'd1;
      end
      busy <= busy_nxt;
      // Double reservation without an intervening write means decode issued
      // a second producer while the first was still in flight.
      if (rsv_ok && busy[bus.rsv_addr] && !(wr_ok && (bus.wr_addr == bus.rsv_addr)))
        sb_err_q <= 1'b1;
      dbg_q <= addr_ok(bus.dbg_addr) ? regs[bus.dbg_addr] : '0;
    end
  end

  assign bus.sb_err   = sb_err_q;
  assign bus.wr_count = wr_count_q;
  assign bus.dbg_data = dbg_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb
//   Directed bench for regfile_sb (NREGS=24 so out-of-range addresses exist).
//   Stimulus drives inputs #1 after each rising edge and queues the values
//   the outputs must show during that cycle; a monitor on the falling edge
//   pops the queue and compares.
module tb_regfile_sb;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int NREGS = 24;

  typedef enum {F_RD1, F_RD2, F_BUSY1, F_BUSY2, F_SBERR, F_DBG, F_WRCNT} field_e;

  typedef struct {
    int          cyc;
    field_e      f;
    logic [31:0] v;
    string       name;
  } exp_t;

  logic clock;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb_q[$];

  regfile_sb_if #(.XLEN(XLEN), .AW(AW)) bus ();

  regfile_sb #(
    .XLEN    (XLEN),
    .NREGS   (NREGS),
    .AW      (AW),
    .ZERO_REG(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic [31:0] pick(input field_e f);
    case (f)
      F_RD1:   return bus.rd_data_1;
      F_RD2:   return bus.rd_data_2;
      F_BUSY1: return {31'd0, bus.busy_1};
      F_BUSY2: return {31'd0, bus.busy_2};
      F_SBERR: return {31'd0, bus.sb_err};
      F_DBG:   return bus.dbg_data;
      default: return bus.wr_count;
    endcase
  endfunction

  // Monitor: compares every expectation queued for the current cycle.
  always @(negedge clock) begin : monitor
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      check(e.name, pick(e.f), e.v);
    end
  end

  task automatic expect_v(input field_e f, input logic [31:0] v, input string name);
    exp_t e;
    e.cyc  = cyc;
    e.f    = f;
    e.v    = v;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.wr_en  = 1'b0;
    bus.rsv_en = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
  endtask

  task automatic do_rsv(input logic [AW-1:0] a);
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = a;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench timed out");
  end

  initial begin : stim
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_addr_1 = '0; bus.rd_addr_2 = '0;
    bus.rsv_en = 1'b0; bus.rsv_addr = '0; bus.dbg_addr = '0;

    // Held in reset
    tick();
    bus.rd_addr_1 = 5'd5; bus.rd_addr_2 = 5'd7;
    expect_v(F_RD1,   0, "rst_rd1");
    expect_v(F_RD2,   0, "rst_rd2");
    expect_v(F_BUSY1, 0, "rst_busy1");
    expect_v(F_BUSY2, 0, "rst_busy2");
    expect_v(F_SBERR, 0, "rst_sberr");
    expect_v(F_DBG,   0, "rst_dbg");
    expect_v(F_WRCNT, 0, "rst_wrcnt");
    tick();
    reset = 1'b1;

    // Every address on both ports reads zero and not busy
    for (int a = 0; a < 32; a++) begin
      tick();
      bus.rd_addr_1 = AW'(a);
      bus.rd_addr_2 = AW'(31 - a);
      expect_v(F_RD1,   0, "sweep_rd1");
      expect_v(F_RD2,   0, "sweep_rd2");
      expect_v(F_BUSY1, 0, "sweep_busy1");
      expect_v(F_BUSY2, 0, "sweep_busy2");
    end
    tick();
    expect_v(F_DBG,   0, "post_rst_dbg");
    expect_v(F_WRCNT, 0, "post_rst_wrcnt");
    expect_v(F_SBERR, 0, "post_rst_sberr");

    // Write r5 with same-cycle bypass
    tick(); do_write(5'd5, 32'hDEADBEEF); bus.rd_addr_1 = 5'd5;
    expect_v(F_RD1, 32'hDEADBEEF, "bypass_r5");
    expect_v(F_WRCNT, 0, "wrcnt_before_edge");
    tick(); idle();
    expect_v(F_RD1, 32'hDEADBEEF, "stored_r5");
    expect_v(F_WRCNT, 1, "wrcnt_1");

    // r0 is hardwired zero
    tick(); do_write(5'd0, 32'h1234); bus.rd_addr_1 = 5'd0; bus.rd_addr_2 = 5'd0;
    expect_v(F_RD1, 0, "r0_no_bypass1");
    expect_v(F_RD2, 0, "r0_no_bypass2");
    tick(); idle(); do_rsv(5'd0);
    expect_v(F_RD1, 0, "r0_stored");
    expect_v(F_WRCNT, 1, "r0_wr_not_counted");
    expect_v(F_BUSY1, 0, "r0_busy_comb");

    // r0 reservation ignored; reserve r7
    tick(); idle(); do_rsv(5'd7); bus.rd_addr_2 = 5'd7;
    expect_v(F_BUSY1, 0, "r0_rsv_ignored");
    expect_v(F_SBERR, 0, "r0_rsv_no_err");
    expect_v(F_BUSY2, 0, "r7_busy_not_yet");
    tick(); idle(); bus.rd_addr_1 = 5'd7;
    expect_v(F_BUSY1, 1, "r7_busy");
    expect_v(F_BUSY2, 1, "r7_busy_port2");

    // Write r7 clears busy combinationally
    tick(); do_write(5'd7, 32'h77); bus.rd_addr_2 = 5'd5;
    expect_v(F_BUSY1, 0, "r7_busy_comb_clear");
    expect_v(F_RD1, 32'h77, "r7_bypass");
    expect_v(F_RD2, 32'hDEADBEEF, "r5_port2");
    expect_v(F_BUSY2, 0, "r5_not_busy");
    tick(); idle();
    expect_v(F_BUSY1, 0, "r7_busy_cleared");
    expect_v(F_RD1, 32'h77, "r7_stored");
    expect_v(F_WRCNT, 2, "wrcnt_2");

    // Reserve and write r7 on the same edge: reservation wins
    tick(); do_write(5'd7, 32'h7777); do_rsv(5'd7);
    expect_v(F_BUSY1, 0, "r7_rsvwr_comb");
    expect_v(F_RD1, 32'h7777, "r7_rsvwr_bypass");
    tick(); idle();
    expect_v(F_BUSY1, 1, "r7_rsv_wins");
    expect_v(F_RD1, 32'h7777, "r7_rsvwr_data");
    expect_v(F_SBERR, 0, "rsvwr_no_err");
    expect_v(F_WRCNT, 3, "wrcnt_3");

    // Re-reserve a busy r7 while it is written: not an error
    tick(); do_write(5'd7, 32'h1); do_rsv(5'd7);
    expect_v(F_BUSY1, 0, "r7_busy_written_comb");
    tick(); idle();
    expect_v(F_BUSY1, 1, "r7_rebusy");
    expect_v(F_SBERR, 0, "busy_written_no_err");
    expect_v(F_RD1, 32'h1, "r7_data_1");
    expect_v(F_WRCNT, 4, "wrcnt_4");

    // Double reservation of r3 sets sticky sb_err
    tick(); do_rsv(5'd3); bus.rd_addr_1 = 5'd3;
    expect_v(F_BUSY1, 0, "r3_free");
    tick(); do_rsv(5'd3);
    expect_v(F_BUSY1, 1, "r3_busy");
    expect_v(F_SBERR, 0, "sberr_before_second_edge");
    tick(); idle();
    expect_v(F_BUSY1, 1, "r3_still_busy");
    expect_v(F_SBERR, 1, "sberr_set");
    tick(); do_write(5'd3, 32'h33);
    expect_v(F_BUSY1, 0, "r3_write_comb");
    expect_v(F_SBERR, 1, "sberr_held_1");
    tick(); idle();
    expect_v(F_BUSY1, 0, "r3_cleared");
    expect_v(F_SBERR, 1, "sberr_held_2");
    expect_v(F_WRCNT, 5, "wrcnt_5");

    // Debug port: one-cycle latency, no bypass
    tick(); do_write(5'd9, 32'h55); bus.dbg_addr = 5'd9;
    expect_v(F_DBG, 0, "dbg_r0_prev");
    tick(); idle();
    expect_v(F_DBG, 0, "dbg_no_bypass");
    tick(); bus.dbg_addr = 5'd30;
    expect_v(F_DBG, 32'h55, "dbg_r9");
    tick(); bus.dbg_addr = 5'd5;
    expect_v(F_DBG, 0, "dbg_out_of_range");
    tick(); bus.dbg_addr = 5'd0;
    expect_v(F_DBG, 32'hDEADBEEF, "dbg_r5");

    // Out-of-range address 30 (NREGS=24)
    tick(); do_write(5'd30, 32'hABCD); do_rsv(5'd30);
    bus.rd_addr_1 = 5'd30; bus.rd_addr_2 = 5'd30;
    expect_v(F_RD1, 0, "oor_rd1_bypass");
    expect_v(F_RD2, 0, "oor_rd2_bypass");
    expect_v(F_BUSY1, 0, "oor_busy_comb");
    expect_v(F_WRCNT, 6, "wrcnt_6");
    tick(); idle(); bus.rd_addr_2 = 5'd24;
    expect_v(F_RD1, 0, "oor_rd1");
    expect_v(F_RD2, 0, "oor_rd2_24");
    expect_v(F_BUSY1, 0, "oor_rsv_ignored");
    expect_v(F_WRCNT, 6, "oor_wr_not_counted");

    // Mid-run reset clears everything at once
    tick(); bus.rd_addr_1 = 5'd5; bus.rd_addr_2 = 5'd7;
    expect_v(F_BUSY2, 1, "r7_busy_before_reset");
    tick(); reset = 1'b0;
    expect_v(F_RD1,   0, "mid_rst_rd1");
    expect_v(F_BUSY2, 0, "mid_rst_busy2");
    expect_v(F_SBERR, 0, "mid_rst_sberr");
    expect_v(F_WRCNT, 0, "mid_rst_wrcnt");
    expect_v(F_DBG,   0, "mid_rst_dbg");
    tick(); reset = 1'b1;
    tick(); bus.dbg_addr = 5'd9;
    expect_v(F_RD1, 0, "after_rst_r5");
    expect_v(F_RD2, 0, "after_rst_r7");
    expect_v(F_WRCNT, 0, "after_rst_wrcnt");

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clock);
    #1;
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending want 0 pending", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
